alu_exec_unit: RTL



---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_exec_unit_if.sv | 28 ++
 rtl/alu_seq_mult.sv | 51 +++++
 rtl/alu_exec_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_ERR = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the issuing stage and the ALU.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluctrl;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, aluctrl, opA, opB, out_ready,
    input  in_ready, out_valid, result, zero, ovf, err
  );

  modport slave (
    input  in_valid, aluctrl, opA, opB, out_ready,
    output in_ready, out_valid, result, zero, ovf, err
  );

endinterface

// File: rtl/alu_seq_mult.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles total.
module alu_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;

  // The final partial product is added combinationally so the top can capture it on the done edge.
  assign product = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done    = busy_reg && (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      count_reg  <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
    end else if (busy_reg) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (done) begin
        busy_reg <= 1'b0;
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and registered result/flags.
// Define ALU_MULT_EN to build the iterative multiplier (op 1000) and the BUSY state.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  alu_exec_unit_if.slave bus
);

  state_t           state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             ovf_reg;
  logic             err_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] calc_result;
  logic             calc_ovf;
  logic             calc_err;
  logic             accept;
  logic             is_mul;

  assign bus.in_ready  = (state_reg == IDLE) || ((state_reg == HOLD) && bus.out_ready);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.err       = err_reg;

  assign accept = bus.in_valid && bus.in_ready;
  assign sum    = bus.opA + bus.opB;
  assign diff   = bus.opA - bus.opB;

`ifdef ALU_MULT_EN
  logic             mult_done;
  logic [WIDTH-1:0] mult_product;

  assign is_mul = (bus.aluctrl == ALU_MUL);

  alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (bus.opA),
    .b       (bus.opB),
    .done    (mult_done),
    .product (mult_product)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    calc_result = '0;
    calc_ovf    = 1'b0;
    calc_err    = 1'b0;
    case (bus.aluctrl)
      ALU_AND: calc_result = bus.opA & bus.opB;
      ALU_OR:  calc_result = bus.opA | bus.opB;
      ALU_NOR: calc_result = ~(bus.opA | bus.opB);
      ALU_SLT: calc_result = {{(WIDTH-1){1'b0}}, $signed(bus.opA) < $signed(bus.opB)};
      ALU_ADD: begin
        calc_result = sum;
        calc_ovf    = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) && (sum[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      ALU_SUB: begin
        calc_result = diff;
        calc_ovf    = (bus.opA[WIDTH-1] != bus.opB[WIDTH-1]) && (diff[WIDTH-1] != bus.opA[WIDTH-1]);
      end
      default: calc_err = !is_mul;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if (accept && is_mul) begin
            state_reg     <= BUSY;
            out_valid_reg <= 1'b0;
          end else if (accept) begin
            state_reg     <= HOLD;
            out_valid_reg <= 1'b1;
            result_reg    <= calc_result;
            zero_reg      <= (calc_result == '0);
            ovf_reg       <= calc_ovf;
            err_reg       <= calc_err;
          end else if ((state_reg == HOLD) && bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
`ifdef ALU_MULT_EN
        BUSY: begin
          if (mult_done) begin
            state_reg     <= HOLD;
            out_valid_reg <= 1'b1;
            result_reg    <= mult_product;
            zero_reg      <= (mult_product == '0);
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
